// File: rtl/i2c_step_arbiter.sv
// Shares one byte-level I2C engine between two step-level requesters, one whole transaction per grant.
// Optional step timeout enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_step_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] step_valid,
    input  logic [1:0] step0,
    input  logic [1:0] step1,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    output logic [1:0] grant,
    output logic [1:0] step_ack,
    output logic [1:0] step_done,
    output logic [1:0] step_err,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic [1:0] next_step,
    output logic [7:0] tx_byte,
    input  logic [7:0] rx_byte,
    input  logic       ready
);

    // state       | meaning
    // S_IDLE      | no owner, arbitrate pending requests
    // S_OWN       | owner holds the bus, waiting for its next step or release
    // S_WAIT      | step forwarded, waiting for ready rising edge
    // S_WAIT_FORCE| owner left mid-transaction, waiting for the forced END to finish
    // S_RELEASE   | drop grant, one dead cycle before the next owner
    typedef enum logic [2:0] {
        S_IDLE,
        S_OWN,
        S_WAIT,
        S_WAIT_FORCE,
        S_RELEASE
    } state_t;

    localparam logic [1:0] STEP_END = 2'b00;

    state_t     state, state_nx;
    logic       owner, owner_nx;
    logic       last_owner, last_owner_nx;
    logic       open_txn, open_txn_nx;
    logic       ready_q;
    logic [1:0] cur_step, cur_step_nx;
    logic [1:0] grant_nx, ack_nx, done_nx, err_nx, next_step_nx;
    logic [7:0] rx_data_nx, tx_byte_nx;
    logic       busy_nx;
    logic       ready_edge;
    logic       tmo_hit;
    logic       own_valid, own_req;
    logic [1:0] own_step;
    logic [7:0] own_tx;

    assign ready_edge = ready & ~ready_q;
    assign own_valid  = owner ? step_valid[1] : step_valid[0];
    assign own_req    = owner ? req[1] : req[0];
    assign own_step   = owner ? step1 : step0;
    assign own_tx     = owner ? tx1 : tx0;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt;

    // Counter is held at zero outside the wait states, so it restarts on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT || state == S_WAIT_FORCE) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == S_WAIT || state == S_WAIT_FORCE) && (tmo_cnt >= TMO_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            open_txn   <= 1'b0;
            ready_q    <= 1'b1;
            cur_step   <= STEP_END;
            grant      <= 2'b00;
            step_ack   <= 2'b00;
            step_done  <= 2'b00;
            step_err   <= 2'b00;
            rx_data    <= 8'h00;
            busy       <= 1'b0;
            next_step  <= 2'b00;
            tx_byte    <= 8'h00;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            open_txn   <= open_txn_nx;
            ready_q    <= ready;
            cur_step   <= cur_step_nx;
            grant      <= grant_nx;
            step_ack   <= ack_nx;
            step_done  <= done_nx;
            step_err   <= err_nx;
            rx_data    <= rx_data_nx;
            busy       <= busy_nx;
            next_step  <= next_step_nx;
            tx_byte    <= tx_byte_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        open_txn_nx   = open_txn;
        cur_step_nx   = cur_step;
        grant_nx      = grant;
        busy_nx       = busy;
        ack_nx        = 2'b00;
        done_nx       = 2'b00;
        err_nx        = 2'b00;
        rx_data_nx    = rx_data;
        next_step_nx  = next_step;
        tx_byte_nx    = tx_byte;

        case (state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester that did not own last goes first.
                    owner_nx    = (req == 2'b11) ? ~last_owner : req[1];
                    grant_nx    = owner_nx ? 2'b10 : 2'b01;
                    busy_nx     = 1'b1;
                    open_txn_nx = 1'b0;
                    state_nx    = S_OWN;
                end
            end
            S_OWN: begin
                if (own_valid) begin
                    cur_step_nx     = own_step;
                    next_step_nx    = own_step;
                    tx_byte_nx      = own_tx;
                    ack_nx[owner]   = 1'b1;
                    open_txn_nx     = (own_step != STEP_END);
                    state_nx        = S_WAIT;
                end else if (!own_req) begin
                    if (open_txn) begin
                        // Owner walked away mid-transaction: close it with an END of our own.
                        next_step_nx = STEP_END;
                        tx_byte_nx   = 8'h00;
                        state_nx     = S_WAIT_FORCE;
                    end else begin
                        state_nx = S_RELEASE;
                    end
                end
            end
            S_WAIT: begin
                if (ready_edge) begin
                    rx_data_nx     = rx_byte;
                    done_nx[owner] = 1'b1;
                    state_nx       = (cur_step == STEP_END) ? S_RELEASE : S_OWN;
                end else if (tmo_hit) begin
                    err_nx[owner] = 1'b1;
                    next_step_nx  = STEP_END;
                    state_nx      = S_RELEASE;
                end
            end
            S_WAIT_FORCE: begin
                if (ready_edge) begin
                    state_nx = S_RELEASE;
                end else if (tmo_hit) begin
                    err_nx[owner] = 1'b1;
                    next_step_nx  = STEP_END;
                    state_nx      = S_RELEASE;
                end
            end
            S_RELEASE: begin
                grant_nx      = 2'b00;
                busy_nx       = 1'b0;
                last_owner_nx = owner;
                next_step_nx  = STEP_END;
                tx_byte_nx    = 8'h00;
                state_nx      = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_step_arbiter.sv
// Scoreboard bench for i2c_step_arbiter: stimulus pushes expected ack/done/err events, a monitor pops them.
module tb_i2c_step_arbiter;

    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_TX    = 2'b10;
    localparam logic [1:0] ST_RX    = 2'b11;
    localparam logic [1:0] ST_END   = 2'b00;
    localparam logic [1:0] K_ACK    = 2'd0;
    localparam logic [1:0] K_DONE   = 2'd1;
    localparam logic [1:0] K_ERR    = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       who;
        logic [1:0] code;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  watch_a5 = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] step_valid = 2'b00;
    logic [1:0] step0 = 2'b00;
    logic [1:0] step1 = 2'b00;
    logic [7:0] tx0 = 8'h00;
    logic [7:0] tx1 = 8'h00;
    logic [7:0] rx_byte = 8'h00;
    logic       ready = 1'b1;
    logic [1:0] grant, step_ack, step_done, step_err, next_step;
    logic [7:0] rx_data, tx_byte;
    logic       busy;

    i2c_step_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .step_valid(step_valid),
        .step0(step0), .step1(step1), .tx0(tx0), .tx1(tx1),
        .grant(grant), .step_ack(step_ack), .step_done(step_done), .step_err(step_err),
        .rx_data(rx_data), .busy(busy), .next_step(next_step), .tx_byte(tx_byte),
        .rx_byte(rx_byte), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req_v, $time);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [1:0] kind, input logic who,
                           input logic [1:0] code, input logic [7:0] data);
        ev_t got, want;
        got = '{kind, who, code, data};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s actual=%0h required=none t=%0t", name, got, $time);
        end else begin
            want = exp_q.pop_front();
            check(name, 32'(got), 32'(want));
        end
    endtask

    // Monitor: every ack/done/err the DUT presents must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int r = 0; r < 2; r++) begin
                    if (step_ack[r])  pop_cmp("ack",  K_ACK,  r[0], next_step, tx_byte);
                    if (step_done[r]) pop_cmp("done", K_DONE, r[0], 2'b00, rx_data);
                    if (step_err[r])  pop_cmp("err",  K_ERR,  r[0], next_step, 8'h00);
                end
                if (watch_a5 && grant == 2'b01) check("a5_leak", 32'(tx_byte == 8'hA5), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic wait_grant(input logic [1:0] g, input string name);
        int n = 0;
        while (grant !== g && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(grant), 32'(g));
    endtask

    task automatic issue(input int r, input logic [1:0] code, input logic [7:0] b);
        int n = 0;
        exp_q.push_back('{K_ACK, r[0], code, b});
        if (r == 0) begin step0 = code; tx0 = b; end
        else        begin step1 = code; tx1 = b; end
        step_valid[r] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!step_ack[r] && n < 60);
        check("ack_seen", 32'(step_ack[r]), 32'd1);
        step_valid[r] = 1'b0;
    endtask

    task automatic complete(input int r, input logic [7:0] rx);
        repeat (2) @(negedge clk);
        rx_byte = rx;
        exp_q.push_back('{K_DONE, r[0], 2'b00, rx});
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic do_step(input int r, input logic [1:0] code, input logic [7:0] b, input logic [7:0] rx);
        issue(r, code, b);
        complete(r, rx);
    endtask

    initial begin
        // Reset with ready held high: release must not look like a completion.
        repeat (3) @(negedge clk);
        check("rst_outputs", {grant, step_ack, step_done, step_err, busy, next_step},
              32'd0);
        check("rst_data", {rx_data, tx_byte}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("no_done_after_rst", 32'(step_done), 32'd0);
        ready = 1'b0;
        @(negedge clk);

        // 1: single requester, full read transaction
        req = 2'b01;
        wait_grant(2'b01, "t1_grant");
        check("t1_busy", 32'(busy), 32'd1);
        do_step(0, ST_START, 8'h90, 8'h00);
        do_step(0, ST_TX,    8'h00, 8'h00);
        do_step(0, ST_START, 8'h91, 8'h00);
        do_step(0, ST_RX,    8'h00, 8'h1A);
        check("t1_rx4", 32'(rx_data), 32'h1A);
        do_step(0, ST_RX,    8'hFF, 8'h80);
        check("t1_rx5", 32'(rx_data), 32'h80);
        issue(0, ST_END, 8'h00);
        req = 2'b00;
        complete(0, 8'h80);
        check("t1_grant_hold", 32'(grant), 32'h1);
        @(negedge clk);
        check("t1_grant_low", {grant, busy}, 32'd0);

        // 2: round robin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 2'b11;
        wait_grant(2'b01, "t2_first");
        do_step(0, ST_START, 8'h20, 8'h00);
        issue(0, ST_END, 8'h00);
        req = 2'b10;
        complete(0, 8'h00);
        check("t2_hold", 32'(grant), 32'h1);
        @(negedge clk);
        check("t2_dead", 32'(grant), 32'h0);
        @(negedge clk);
        check("t2_r1", 32'(grant), 32'h2);
        req = 2'b11;
        issue(1, ST_END, 8'h00);
        complete(1, 8'h55);
        check("t2_r1_rx", 32'(rx_data), 32'h55);
        @(negedge clk);
        check("t2_dead2", 32'(grant), 32'h0);
        @(negedge clk);
        check("t2_back_r0", 32'(grant), 32'h1);

        // 3: R1 presses a step while R0 owns
        step1 = ST_START;
        tx1 = 8'hA5;
        step_valid[1] = 1'b1;
        watch_a5 = 1'b1;
        do_step(0, ST_START, 8'h3C, 8'h00);
        do_step(0, ST_TX,    8'h42, 8'h00);
        issue(0, ST_END, 8'h00);
        req = 2'b10;
        complete(0, 8'h00);
        watch_a5 = 1'b0;
        issue(1, ST_START, 8'hA5);
        complete(1, 8'h00);
        issue(1, ST_END, 8'h00);
        req = 2'b00;
        complete(1, 8'h00);
        repeat (2) @(negedge clk);
        check("t3_released", 32'(grant), 32'h0);

        // 4: owner drops req mid-transaction
        req = 2'b01;
        wait_grant(2'b01, "t4_grant");
        do_step(0, ST_START, 8'h40, 8'h00);
        check("t4_pre", 32'(next_step), 32'(ST_START));
        req = 2'b00;
        @(negedge clk);
        check("t4_force_end", {grant, next_step}, {28'd0, 2'b01, ST_END});
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("t4_no_done", 32'(step_done), 32'd0);
        @(negedge clk);
        check("t4_grant_low", 32'(grant), 32'h0);

        // 5: stuck engine
        req = 2'b01;
        wait_grant(2'b01, "t5_grant");
        issue(0, ST_START, 8'h90);
`ifdef I2C_ARB_TIMEOUT_EN
        exp_q.push_back('{K_ERR, 1'b0, ST_END, 8'h00});
        repeat (15) @(negedge clk);
        check("t5_err_early", 32'(step_err), 32'd0);
        @(negedge clk);
        check("t5_err", {step_err, next_step}, {28'd0, 2'b01, ST_END});
        req = 2'b00;
        @(negedge clk);
        check("t5_grant_low", 32'(grant), 32'h0);
        req = 2'b01;
        wait_grant(2'b01, "t6_pre_grant");
        issue(0, ST_START, 8'h90);
`else
        repeat (30) @(negedge clk);
        check("t5_no_tmo", {step_err, grant}, {28'd0, 2'b00, 2'b01});
`endif

        // 6: async reset mid-WAIT
        #2 rst = 1'b1;
        #1 check("t6_async", {grant, busy, next_step, tx_byte}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_grant(2'b01, "t6_regrant");
        issue(0, ST_END, 8'h00);
        req = 2'b00;
        complete(0, 8'h00);
        repeat (3) @(negedge clk);
        check("t6_done", 32'(grant), 32'h0);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
